// File: rtl/alu_input_register_if.sv
// ALU operand-capture bundle: bus inputs, load strobes, handshake, operands.
// Optional conflict_err signal when ALU_INPUT_CONFLICT_CHECK_EN is defined.
interface alu_input_register_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] db;
    logic [WIDTH-1:0] adl;
    logic             zero_add;
    logic             sb_add;
    logic             db_add;
    logic             ndb_add;
    logic             adl_add;
    logic             carry_in;
    logic             alu_ack;
    logic [WIDTH-1:0] a_out;
    logic [WIDTH-1:0] b_out;
    logic             cin_out;
    logic             operands_valid;
    logic             stale;
`ifdef ALU_INPUT_CONFLICT_CHECK_EN
    logic             conflict_err;

    modport master (
        output sb, db, adl, zero_add, sb_add, db_add, ndb_add, adl_add,
        output carry_in, alu_ack,
        input  a_out, b_out, cin_out, operands_valid, stale, conflict_err
    );
    modport slave (
        input  sb, db, adl, zero_add, sb_add, db_add, ndb_add, adl_add,
        input  carry_in, alu_ack,
        output a_out, b_out, cin_out, operands_valid, stale, conflict_err
    );
`else
    modport master (
        output sb, db, adl, zero_add, sb_add, db_add, ndb_add, adl_add,
        output carry_in, alu_ack,
        input  a_out, b_out, cin_out, operands_valid, stale
    );
    modport slave (
        input  sb, db, adl, zero_add, sb_add, db_add, ndb_add, adl_add,
        input  carry_in, alu_ack,
        output a_out, b_out, cin_out, operands_valid, stale
    );
`endif
endinterface

// File: rtl/alu_input_register.sv
// ALU operand latch: samples A/B/carry from precharged buses, valid/ack out.
// Optional sticky select-conflict flag: define ALU_INPUT_CONFLICT_CHECK_EN.
module alu_input_register #(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 3
) (
    input logic                 clk,
    input logic                 reset_n,
    alu_input_register_if.slave bus
);
    localparam int CW = $clog2(MAX_HOLD + 2);
    localparam logic [CW-1:0] SAT  = CW'(MAX_HOLD + 1);
    localparam logic [CW-1:0] HOLD = CW'(MAX_HOLD);

    typedef enum logic [1:0] {
        IDLE,
        HAVE_A,
        HAVE_B,
        READY
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             cin_q, cin_d;
    logic             valid_q, valid_d;
    logic             stale_q, stale_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sb_r, db_r, adl_r, b_src;
    logic             load_a, load_b, ack_rdy;
    logic             has_a, has_b;

    // Precharged bus: undriven (z) or unknown bits read as 1.
    function automatic logic [WIDTH-1:0] resolve(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = (v[i] === 1'b0) ? 1'b0 : 1'b1;
        end
        return r;
    endfunction

    // Operand selection, handshake FSM and hold counter next-state.
    always_comb begin
        sb_r    = resolve(bus.sb);
        db_r    = resolve(bus.db);
        adl_r   = resolve(bus.adl);
        load_a  = bus.zero_add | bus.sb_add;
        load_b  = bus.db_add | bus.ndb_add | bus.adl_add;
        ack_rdy = (state_q == READY) & bus.alu_ack;

        a_d = a_q;
        if (load_a) a_d = bus.zero_add ? '0 : sb_r;

        b_src = '1;
        if (bus.db_add)  b_src = b_src & db_r;
        if (bus.ndb_add) b_src = b_src & ~db_r;
        if (bus.adl_add) b_src = b_src & adl_r;
        b_d = load_b ? b_src : b_q;

        cin_d = (load_a | load_b) ? bus.carry_in : cin_q;

        has_a = ((state_q == HAVE_A) | (state_q == READY)) & ~ack_rdy;
        has_b = ((state_q == HAVE_B) | (state_q == READY)) & ~ack_rdy;
        has_a = has_a | load_a;
        has_b = has_b | load_b;

        state_d = IDLE;
        unique case ({has_a, has_b})
            2'b00: state_d = IDLE;
            2'b10: state_d = HAVE_A;
            2'b01: state_d = HAVE_B;
            2'b11: state_d = READY;
        endcase

        // Count includes the current READY cycle; fresh operands restart at 1.
        cnt_d = '0;
        if (state_d == READY) begin
            if (load_a | load_b)  cnt_d = CW'(1);
            else if (cnt_q < SAT) cnt_d = cnt_q + CW'(1);
            else                  cnt_d = cnt_q;
        end

        valid_d = (state_d == READY);
        stale_d = (cnt_d > HOLD);
    end

    // Operand, handshake and counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            cin_q   <= 1'b0;
            valid_q <= 1'b0;
            stale_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cin_q   <= cin_d;
            valid_q <= valid_d;
            stale_q <= stale_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.a_out          = a_q;
    assign bus.b_out          = b_q;
    assign bus.cin_out        = cin_q;
    assign bus.operands_valid = valid_q;
    assign bus.stale          = stale_q;

`ifdef ALU_INPUT_CONFLICT_CHECK_EN
    logic conf_q, conf_d;
    logic multi_b;

    // Sticky flag for wired-AND B selects or A priority collisions.
    always_comb begin
        multi_b = (bus.db_add & bus.ndb_add) | (bus.db_add & bus.adl_add)
                | (bus.ndb_add & bus.adl_add);
        conf_d  = conf_q | multi_b | (bus.zero_add & bus.sb_add);
    end

    // Conflict register, cleared only by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) conf_q <= 1'b0;
        else          conf_q <= conf_d;
    end

    assign bus.conflict_err = conf_q;
`endif
endmodule

// File: tb/tb_alu_input_register.sv
// Directed bench for alu_input_register with an expected-value queue.
// Define ALU_INPUT_CONFLICT_CHECK_EN to also check conflict_err.
module tb_alu_input_register;
    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    alu_input_register_if #(.WIDTH(8)) bif ();

    alu_input_register #(.WIDTH(8), .MAX_HOLD(3)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bif)
    );

    // sb is a precharged tristate bus so "undriven" is a real test input.
    logic       sb_oe;
    logic [7:0] sb_drv;
    wire  [7:0] sb_net;
    assign sb_net = sb_oe ? sb_drv : 8'bzzzz_zzzz;
    for (genvar i = 0; i < 8; i++) begin : g_pu
        pullup (sb_net[i]);
    end
    assign bif.sb = sb_net;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       v;
        logic       s;
        logic       conf;
    } exp_t;

    exp_t exp_q[$];
    logic exp_conf;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic drive(input logic za, input logic sa, input logic da,
                         input logic nda, input logic ada, input logic cin,
                         input logic ack, input logic oe,
                         input logic [7:0] sbv, input logic [7:0] dbv,
                         input logic [7:0] adlv);
        bif.zero_add = za;
        bif.sb_add   = sa;
        bif.db_add   = da;
        bif.ndb_add  = nda;
        bif.adl_add  = ada;
        bif.carry_in = cin;
        bif.alu_ack  = ack;
        sb_oe        = oe;
        sb_drv       = sbv;
        bif.db       = dbv;
        bif.adl      = adlv;
    endtask

    task automatic step(input string tag, input logic [7:0] a,
                        input logic [7:0] b, input logic cin,
                        input logic v, input logic s);
        exp_t e;
        exp_t g;
        e = '{tag, a, b, cin, v, s, exp_conf};
        exp_q.push_back(e);
        @(negedge clk);
        g = exp_q.pop_front();
        chk({g.tag, ".a"},   32'(bif.a_out),          32'(g.a));
        chk({g.tag, ".b"},   32'(bif.b_out),          32'(g.b));
        chk({g.tag, ".cin"}, 32'(bif.cin_out),        32'(g.cin));
        chk({g.tag, ".v"},   32'(bif.operands_valid), 32'(g.v));
        chk({g.tag, ".s"},   32'(bif.stale),          32'(g.s));
`ifdef ALU_INPUT_CONFLICT_CHECK_EN
        chk({g.tag, ".conf"}, 32'(bif.conflict_err), 32'(g.conf));
`endif
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".a"},   32'(bif.a_out),          32'h0);
        chk({tag, ".b"},   32'(bif.b_out),          32'h0);
        chk({tag, ".cin"}, 32'(bif.cin_out),        32'h0);
        chk({tag, ".v"},   32'(bif.operands_valid), 32'h0);
        chk({tag, ".s"},   32'(bif.stale),          32'h0);
`ifdef ALU_INPUT_CONFLICT_CHECK_EN
        chk({tag, ".conf"}, 32'(bif.conflict_err), 32'h0);
`endif
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        exp_conf = 1'b0;
        reset_n  = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h00);
        repeat (2) @(negedge clk);
        chk_zero("reset");
        reset_n = 1'b1;

        // A then B, operands_valid one cycle after the completing B load
        drive(0, 1, 0, 0, 0, 0, 0, 1, 8'h12, 8'h00, 8'h00);
        step("loadA", 8'h12, 8'h00, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 1, 0, 1, 8'h00, 8'h34, 8'h00);
        step("loadB", 8'h12, 8'h34, 1, 1, 0);

        // Hold without ack: stale from the 4th READY cycle, saturating
        drive(0, 0, 0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h00);
        step("hold2", 8'h12, 8'h34, 1, 1, 0);
        step("hold3", 8'h12, 8'h34, 1, 1, 0);
        step("hold4", 8'h12, 8'h34, 1, 1, 1);
        step("hold5", 8'h12, 8'h34, 1, 1, 1);

        // Ack with a new A load: HAVE_A, stale and valid drop
        drive(0, 1, 0, 0, 0, 0, 1, 1, 8'h77, 8'h00, 8'h00);
        step("ackA", 8'h77, 8'h34, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 1, 8'h00, 8'h00, 8'h00);
        step("ackIgn", 8'h77, 8'h34, 0, 0, 0);

        // Inverted db load completes the pair
        drive(0, 0, 0, 1, 0, 1, 0, 1, 8'h00, 8'h0F, 8'h00);
        step("ndb", 8'h77, 8'hF0, 1, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 1, 8'h00, 8'h00, 8'h00);
        step("ack", 8'h77, 8'hF0, 1, 0, 0);

        // Wired-AND of adl and db
`ifdef ALU_INPUT_CONFLICT_CHECK_EN
        exp_conf = 1'b1;
`endif
        drive(0, 0, 1, 0, 1, 0, 0, 1, 8'h00, 8'hA5, 8'hC3);
        step("wand", 8'h77, 8'h81, 0, 0, 0);

        // Undriven sb reads as all ones
        drive(0, 1, 0, 0, 0, 1, 0, 0, 8'h00, 8'h00, 8'h00);
        step("sbz", 8'hFF, 8'h81, 1, 1, 0);

        // zero_add wins over sb_add, reload in READY stays READY
        drive(1, 1, 0, 0, 0, 0, 0, 1, 8'h55, 8'h00, 8'h00);
        step("zprio", 8'h00, 8'h81, 0, 1, 0);

        // Ack with A&B load stays READY
        drive(1, 0, 1, 0, 0, 1, 1, 1, 8'h00, 8'h11, 8'h00);
        step("ackAB", 8'h00, 8'h11, 1, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 1, 8'h00, 8'h00, 8'h00);
        step("ack2", 8'h00, 8'h11, 1, 0, 0);

        // Build READY with a_out=5A, then async reset mid-cycle
        drive(0, 1, 0, 0, 0, 0, 0, 1, 8'h5A, 8'h00, 8'h00);
        step("preA", 8'h5A, 8'h11, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 1, 0, 1, 8'h00, 8'h00, 8'h66);
        step("preB", 8'h5A, 8'h66, 1, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h00);
        #2 reset_n = 1'b0;
        #1 chk_zero("async_rst");
        exp_conf = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;

        // After reset the FSM is IDLE: a lone B load is not enough
        drive(0, 0, 1, 0, 0, 0, 0, 1, 8'h00, 8'h01, 8'h00);
        step("postB", 8'h00, 8'h01, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0, 0, 1, 8'h02, 8'h00, 8'h00);
        step("postA", 8'h02, 8'h01, 0, 1, 0);

        chk("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
